// File: rtl/ex_forwarding_network.sv
// ex_forwarding_network
// EX-stage operand forwarding with a built-in DEPTH-entry history of
// in-flight register writes (index 0 = youngest). Each of NUM_RD read ports
// takes the youngest matching write; a youngest match whose load data has not
// arrived yet raises hazard_o instead. Late load data enters through the fill
// port into history entry FILL_IDX.
// Optional build macro: FWD_STATS_EN adds saturating stall_cnt_o / fwd_cnt_o.
//
// Pipeline contract: advance_i=1 means the EX instruction moves on this edge
// and its write is recorded; advance_i=0 holds the history (flush_i ignored).
// The surrounding pipeline must keep advance_i=0 while hazard_o=1.
module ex_forwarding_network #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int DEPTH    = 2,
   parameter int FILL_IDX = 0,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     advance_i,
   input  logic                     flush_i,
   input  logic                     wr_en_i,
   input  logic [ADDR_W-1:0]        wr_addr_i,
   input  logic [DATA_W-1:0]        wr_data_i,
   input  logic                     wr_ready_i,
   input  logic                     fill_en_i,
   input  logic [DATA_W-1:0]        fill_data_i,
   input  logic [NUM_RD-1:0]        rd_en_i,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   input  logic [NUM_RD*DATA_W-1:0] rd_data_i,
   output logic [NUM_RD*DATA_W-1:0] data_o,
   output logic [NUM_RD-1:0]        fwd_hit_o,
   output logic                     hazard_o
`ifdef FWD_STATS_EN
   ,
   output logic [31:0]              stall_cnt_o,
   output logic [31:0]              fwd_cnt_o
`endif
);

   // A fill arriving while the pipe shifts follows its entry one slot older;
   // from the oldest slot there is nowhere to go, so it is dropped.
   localparam bit FILL_ON_SHIFT = (FILL_IDX < DEPTH - 1);
   localparam int FILL_DST      = FILL_ON_SHIFT ? FILL_IDX + 1 : FILL_IDX;

   logic [DEPTH-1:0]  hist_valid, nxt_valid;
   logic [DEPTH-1:0]  hist_ready, nxt_ready;
   logic [ADDR_W-1:0] hist_addr [DEPTH];
   logic [ADDR_W-1:0] nxt_addr  [DEPTH];
   logic [DATA_W-1:0] hist_data [DEPTH];
   logic [DATA_W-1:0] nxt_data  [DEPTH];
   logic              fill_hit;
   logic [NUM_RD-1:0] pend;

   assign fill_hit = fill_en_i && hist_valid[FILL_IDX] && !hist_ready[FILL_IDX];

   // Next history: optional shift with new EX write, then pending-load fill.
   always_comb begin
      nxt_valid = hist_valid;
      nxt_ready = hist_ready;
      nxt_addr  = hist_addr;
      nxt_data  = hist_data;
      if (advance_i) begin
         for (int k = 1; k < DEPTH; k++) begin
            nxt_valid[k] = hist_valid[k-1];
            nxt_ready[k] = hist_ready[k-1];
            nxt_addr[k]  = hist_addr[k-1];
            nxt_data[k]  = hist_data[k-1];
         end
         nxt_valid[0] = wr_en_i & ~flush_i;
         nxt_ready[0] = wr_ready_i;
         nxt_addr[0]  = wr_addr_i;
         nxt_data[0]  = wr_data_i;
         if (fill_hit && FILL_ON_SHIFT) begin
            nxt_ready[FILL_DST] = 1'b1;
            nxt_data[FILL_DST]  = fill_data_i;
         end
      end else if (fill_hit) begin
         nxt_ready[FILL_IDX] = 1'b1;
         nxt_data[FILL_IDX]  = fill_data_i;
      end
   end

   // History registers; reset invalidates everything including pending loads.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hist_valid <= '0;
         hist_ready <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            hist_addr[k] <= '0;
            hist_data[k] <= '0;
         end
      end else begin
         hist_valid <= nxt_valid;
         hist_ready <= nxt_ready;
         hist_addr  <= nxt_addr;
         hist_data  <= nxt_data;
      end
   end

   // Per-port youngest-match lookup; a not-ready match stalls rather than forwards.
   always_comb begin
      logic [ADDR_W-1:0] ra;
      logic              found;
      logic              elig;
      data_o    = rd_data_i;
      fwd_hit_o = '0;
      pend      = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         ra    = rd_addr_i[p*ADDR_W +: ADDR_W];
         found = 1'b0;
         elig  = rd_en_i[p] && !((ZERO_REG != 0) && (ra == '0));
         for (int i = 0; i < DEPTH; i++) begin
            if (elig && !found && hist_valid[i] && (hist_addr[i] == ra)) begin
               found = 1'b1;
               if (hist_ready[i]) begin
                  data_o[p*DATA_W +: DATA_W] = hist_data[i];
                  fwd_hit_o[p]               = 1'b1;
               end else begin
                  pend[p] = 1'b1;
               end
            end
         end
      end
   end

   assign hazard_o = |pend;

`ifdef FWD_STATS_EN
   logic [31:0] hit_cnt;
   logic [32:0] fwd_sum;

   // Number of ports forwarding this cycle.
   always_comb begin
      hit_cnt = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         hit_cnt = hit_cnt + {31'b0, fwd_hit_o[p]};
      end
   end

   assign fwd_sum = {1'b0, fwd_cnt_o} + {1'b0, hit_cnt};

   // Saturating stall and forward counters.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stall_cnt_o <= '0;
         fwd_cnt_o   <= '0;
      end else begin
         if (hazard_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 32'd1;
         fwd_cnt_o <= fwd_sum[32] ? '1 : fwd_sum[31:0];
      end
   end
`endif

endmodule
